// File: rtl/pdm_decimator.sv
// PDM-to-PCM decimator: 3rd-order CIC with power-of-two ratio, 3-event warm-up,
// and a single-entry valid/ready output register with sticky overrun flag.
module pdm_decimator #(
  parameter int LOG2_DECIM = 6,
  parameter int OUT_W      = 16,
  parameter int ACC_W      = 3*LOG2_DECIM+1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pdm_ce,
  input  logic             pdm_in,
  output logic [OUT_W-1:0] sample_out,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun
);

  localparam int SHIFT = 3*LOG2_DECIM - OUT_W;
  localparam logic [LOG2_DECIM-1:0] DEC_ONE  = {{(LOG2_DECIM-1){1'b0}}, 1'b1};
  localparam logic [LOG2_DECIM-1:0] DEC_LAST = '1;
  localparam logic [1:0]            WARM_DONE = 2'd3;

  logic [ACC_W-1:0]      r_i1, r_i2, r_i3;
  logic [ACC_W-1:0]      r_d1, r_d2, r_d3;
  logic [LOG2_DECIM-1:0] r_dec_cnt;
  logic [1:0]            r_warm_cnt;
  logic [OUT_W-1:0]      r_sample;
  logic                  r_valid;
  logic                  r_overrun;

  logic [ACC_W-1:0] w_i1_next, w_i2_next, w_i3_next;
  logic [ACC_W-1:0] w_c1, w_c2, w_c3, w_scaled;
  logic [OUT_W-1:0] w_y;
  logic             w_dec_evt;
  logic             w_produce;

  // Integrators chain through the freshly updated previous stage; wrap is intended.
  always_comb begin
    w_i1_next = r_i1 + {{(ACC_W-1){1'b0}}, pdm_in};
    w_i2_next = r_i2 + w_i1_next;
    w_i3_next = r_i3 + w_i2_next;
    w_c1      = w_i3_next - r_d1;
    w_c2      = w_c1 - r_d2;
    w_c3      = w_c2 - r_d3;
    w_scaled  = w_c3 >> SHIFT;
    w_y       = (|w_scaled[ACC_W-1:OUT_W]) ? '1 : w_scaled[OUT_W-1:0];
    w_dec_evt = pdm_ce && (r_dec_cnt == DEC_LAST);
    w_produce = w_dec_evt && (r_warm_cnt == WARM_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_i1       <= '0;
      r_i2       <= '0;
      r_i3       <= '0;
      r_d1       <= '0;
      r_d2       <= '0;
      r_d3       <= '0;
      r_dec_cnt  <= '0;
      r_warm_cnt <= '0;
      r_sample   <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (pdm_ce) begin
        r_i1      <= w_i1_next;
        r_i2      <= w_i2_next;
        r_i3      <= w_i3_next;
        r_dec_cnt <= r_dec_cnt + DEC_ONE;
      end
      if (w_dec_evt) begin
        r_d1 <= w_i3_next;
        r_d2 <= w_c1;
        r_d3 <= w_c2;
        if (r_warm_cnt != WARM_DONE)
          r_warm_cnt <= r_warm_cnt + 2'd1;
      end
      // A slot frees up when empty or when the held sample is consumed this cycle.
      if (w_produce && (!r_valid || sample_ready)) begin
        r_sample <= w_y;
        r_valid  <= 1'b1;
      end else if (w_produce) begin
        r_overrun <= 1'b1;
      end else if (r_valid && sample_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign sample_out   = r_sample;
  assign sample_valid = r_valid;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_pdm_decimator.sv
// Directed bench for pdm_decimator (R=64): level recovery, warm-up latency,
// clock-enable gating, backpressure/overrun and mid-period reset.
module tb_pdm_decimator;

  logic        clk;
  logic        reset;
  logic        pdm_ce;
  logic        pdm_in;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        sample_ready;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int ce_num;
  int first_ce;
  int vcnt;
  int bad;

  pdm_decimator #(.LOG2_DECIM(6), .OUT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .pdm_ce       (pdm_ce),
    .pdm_in       (pdm_in),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic ce, input logic b);
    pdm_ce = ce;
    pdm_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    ce_num   = 0;
    first_ce = -1;
    vcnt     = 0;
    bad      = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
    clear_stats();
  endtask

  // Bit for ce index k (0-based since reset) is 1 when (k % period) < ones.
  task automatic run(input int n, input int period, input int ones, input int gap,
                     input logic [15:0] expv);
    logic b;
    for (int k = 0; k < n; k++) begin
      b = ((ce_num % period) < ones);
      ce_num++;
      step(1'b1, b);
      if (sample_valid) begin
        if (first_ce < 0) first_ce = ce_num;
        vcnt++;
        if (sample_out !== expv) bad++;
      end
      for (int g = 0; g < gap; g++)
        step(1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset        = 1'b0;
    pdm_ce       = 1'b0;
    pdm_in       = 1'b0;
    sample_ready = 1'b1;
    clear_stats();

    // Reset state
    do_reset();
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_out", 32'(sample_out), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'd0);

    // Zero input: samples after ce 256,320,...,512
    run(512, 1, 0, 0, 16'h0000);
    chk("zero_first", 32'(first_ce), 32'd256);
    chk("zero_cnt", 32'(vcnt), 32'd5);
    chk("zero_bad", 32'(bad), 32'd0);

    // Full scale saturates to 0xFFFF; accumulators wrap well within this run
    do_reset();
    run(512, 1, 1, 0, 16'hFFFF);
    chk("full_first", 32'(first_ce), 32'd256);
    chk("full_cnt", 32'(vcnt), 32'd5);
    chk("full_bad", 32'(bad), 32'd0);
    chk("full_ovr", 32'(overrun), 32'd0);

    // Half scale
    do_reset();
    run(384, 2, 1, 0, 16'h8000);
    chk("half_first", 32'(first_ce), 32'd256);
    chk("half_cnt", 32'(vcnt), 32'd3);
    chk("half_bad", 32'(bad), 32'd0);

    // Quarter scale
    do_reset();
    run(384, 4, 1, 0, 16'h4000);
    chk("qtr_first", 32'(first_ce), 32'd256);
    chk("qtr_cnt", 32'(vcnt), 32'd3);
    chk("qtr_bad", 32'(bad), 32'd0);

    // Clock-enable gating: ce every 4th clk, noise on idle cycles
    do_reset();
    run(320, 2, 1, 3, 16'h8000);
    chk("gate_first", 32'(first_ce), 32'd256);
    chk("gate_cnt", 32'(vcnt), 32'd2);
    chk("gate_bad", 32'(bad), 32'd0);

    // Backpressure: quarter-scale first sample, then full-scale input
    do_reset();
    run(255, 4, 1, 0, 16'h4000);
    chk("bp_pre_valid", 32'(sample_valid), 32'd0);
    sample_ready = 1'b0;
    run(1, 4, 1, 0, 16'h4000);
    chk("bp_first_valid", 32'(sample_valid), 32'd1);
    chk("bp_first_out", 32'(sample_out), 32'h4000);
    run(63, 1, 1, 0, 16'h4000);
    chk("bp_319_ovr", 32'(overrun), 32'd0);
    chk("bp_319_out", 32'(sample_out), 32'h4000);
    run(1, 1, 1, 0, 16'h4000);
    chk("bp_320_ovr", 32'(overrun), 32'd1);
    chk("bp_320_out", 32'(sample_out), 32'h4000);
    chk("bp_320_valid", 32'(sample_valid), 32'd1);
    run(64, 1, 1, 0, 16'h4000);
    chk("bp_384_ovr", 32'(overrun), 32'd1);
    chk("bp_384_out", 32'(sample_out), 32'h4000);
    sample_ready = 1'b1;
    step(1'b0, 1'b0);
    chk("bp_drain_valid", 32'(sample_valid), 32'd0);
    chk("bp_drain_ovr", 32'(overrun), 32'd1);

    // Mid-operation reset at ce 290 with a sample still held
    do_reset();
    sample_ready = 1'b0;
    run(289, 1, 1, 0, 16'hFFFF);
    chk("mr_held_valid", 32'(sample_valid), 32'd1);
    chk("mr_held_out", 32'(sample_out), 32'hFFFF);
    reset = 1'b1;
    step(1'b1, 1'b1);
    reset = 1'b0;
    chk("mr_valid", 32'(sample_valid), 32'd0);
    chk("mr_ovr", 32'(overrun), 32'd0);
    chk("mr_out", 32'(sample_out), 32'h0);
    clear_stats();
    sample_ready = 1'b1;
    run(256, 1, 1, 0, 16'hFFFF);
    chk("mr_first", 32'(first_ce), 32'd256);
    chk("mr_cnt", 32'(vcnt), 32'd1);
    chk("mr_bad", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdm_decimator.md
Name: pdm_decimator

Overview:
Receive-side counterpart of the audio PDM modulator. It accepts a 1-bit PDM bitstream and recovers 16-bit unsigned PCM samples using a 3rd-order CIC decimation filter with a power-of-two decimation ratio. Recovered samples are presented on a single-entry valid/ready output register. The block is used for loopback self-test of the audio PMOD path and as a microphone/PDM input front end.

Parameters:
LOG2_DECIM, 6, log2 of decimation ratio R (R = 2^LOG2_DECIM); legal range 6..10
OUT_W, 16, output sample width; fixed at 16 in this revision
ACC_W, 3*LOG2_DECIM+1, integrator/comb width; derived, do not override

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pdm_ce  in  1  bit strobe; pdm_in is consumed only on cycles with pdm_ce=1
pdm_in  in  1  PDM bit (1 = +full scale, 0 = zero)
sample_out  out  16  decimated PCM sample, unsigned
sample_valid  out  1  sample_out holds an unconsumed sample
sample_ready  in  1  consumer accepts sample when valid&ready
overrun  out  1  sticky: a produced sample was dropped

Behaviour:
- One clock domain: clk. Reset is synchronous, active-high: the design is reset on any rising edge of clk with reset=1.
- Reset values: all three integrators = 0; all comb delay registers = 0; dec_cnt = 0; warm_cnt = 0; sample_out = 0; sample_valid = 0; overrun = 0.
- Reset has priority over every other event, including mid-period. It discards partial accumulations and the held sample.
- Integrators, on each pdm_ce:
  - i1 += pdm_in; i2 += i1_next; i3 += i2_next.
  - Each stage uses the updated value of the previous stage in the same cycle.
  - Arithmetic is unsigned modulo 2^ACC_W. Wrap-around is intentional and must not saturate.
- Cycles with pdm_ce=0 leave all state unchanged. pdm_in is ignored on those cycles.
- Decimation counter:
  - dec_cnt counts pdm_ce pulses from 0 to R-1 and wraps.
  - On the pdm_ce where dec_cnt = R-1, a decimation event fires.
  - The event uses i3_next, which includes the current bit.
- Comb chain, on a decimation event, computed in the same cycle:
  - c1 = i3_next - d1; c2 = c1 - d2; c3 = c2 - d3, all modulo 2^ACC_W.
  - Then d1 <= i3_next, d2 <= c1, d3 <= c2.
- Scaling:
  - y = c3 >> (3*LOG2_DECIM - 16).
  - If y > 0xFFFF, y = 0xFFFF (all-ones input gives exactly 2^16).
- Warm-up:
  - The first 3 decimation events after reset only update combs and increment warm_cnt. They produce no sample.
  - From the 4th event onward, every event produces a sample.
- Output register and handshake:
  - A sample produced with sample_valid=0, or with valid&ready in that same cycle: sample_out <= y and sample_valid <= 1 on the next edge. Latency is 1 clk after the R-th pdm_ce.
  - valid&ready with no new sample: sample_valid <= 0 next edge.
  - While sample_valid=1 and sample_ready=0, sample_out is held stable.
  - A new sample produced while sample_valid=1 and sample_ready=0 is dropped, and overrun <= 1.
  - overrun is cleared only by reset.
- pdm_ce may be asserted every cycle. There is no minimum spacing.

Test Plan:
1. Zero input: reset, then pdm_in=0, pdm_ce=1 every cycle, sample_ready=1 -> no valid before the 256th ce; valid pulses 1 cycle after ce #256, #320, ..., each with sample_out = 0x0000.
2. Full scale: pdm_in=1 constant, same setup -> first sample after ce #256 = 0xFFFF (saturated); every subsequent sample = 0xFFFF; overrun = 0.
3. Half and quarter scale:
   - Alternating 1,0 -> every sample = 0x8000.
   - Pattern 1,0,0,0 -> every sample = 0x4000.
4. Clock enable gating: pattern 1,0 applied only on pdm_ce cycles, pdm_ce every 4th clk, pdm_in randomised on non-ce cycles -> samples = 0x8000; the first valid comes 1 clk after the 256th ce.
5. Backpressure: sample_ready=0 from the first valid for 2 decimation periods -> sample_out stays at the first sample; the second sample is dropped; overrun rises 1 clk after ce #320 and stays 1. Then sample_ready=1 -> valid drops after one handshake and overrun stays 1.
6. Mid-operation reset: reset=1 for one clk at ce #290 -> next edge gives sample_valid=0, overrun=0, sample_out=0; the next valid appears only after 256 further ce pulses.
